// File: rtl/dm_store_buffer.sv
// dm_store_buffer: formats MEM-stage stores into byte-lane words, queues them
// in a small FIFO and drains them to the data memory whenever the shared DM
// address port is not claimed by a load. Loads read DM and merge in any bytes
// still waiting in the queue, so younger loads observe older stores.
module dm_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        req_ready,
  output logic        req_err,
  output logic [31:0] load_data,
  input  logic        drain_stall,
  output logic        sb_empty,
  output logic [31:0] dm_pc,
  output logic [29:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_we,
  input  logic [31:0] dm_rdata
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  we;
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW:0]      r_count;

  logic        w_bad;
  logic        w_err;
  logic        w_load;
  logic        w_enq;
  logic        w_drain;
  logic [3:0]  w_st_we;
  logic [31:0] w_st_data;
  logic [31:0] w_merged;
  logic [31:0] w_shift;
  logic [31:0] w_ext;

  // Classify the request shape: illegal size or an address not aligned to it.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_bad = 1'b0;
    case (req_size)
      2'd0:    w_bad = 1'b0;
      2'd1:    w_bad = req_addr[0];
      2'd2:    w_bad = |req_addr[1:0];
      default: w_bad = 1'b1;
    endcase
  end

  assign w_err   = req_valid & w_bad;
  assign w_load  = req_valid & ~req_we & ~w_err;
  assign req_err = w_err;

  // Place store data into its byte lanes and build the matching write mask.
  always_comb begin
    w_st_we   = 4'b0000;
    w_st_data = req_wdata;
    case (req_size)
      2'd0: begin
        w_st_we   = 4'b0001 << req_addr[1:0];
        w_st_data = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        w_st_we   = req_addr[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{req_wdata[15:0]}};
      end
      default: begin
        w_st_we   = 4'b1111;
        w_st_data = req_wdata;
      end
    endcase
  end

  // Ready comes from the registered count, so a pop frees a slot only next cycle.
  assign req_ready = (r_count != (PW+1)'(DEPTH));
  assign sb_empty  = (r_count == '0);
  assign w_enq     = req_valid & req_we & ~w_err & req_ready;
  // Any load, even an erroring one, owns the DM address port this cycle.
  assign w_drain   = (r_count != '0) & ~drain_stall & ~(req_valid & ~req_we);

  // Drive the DM port from the queue head when draining, else from the request.
  always_comb begin
    dm_we    = 4'b0000;
    dm_wdata = '0;
    dm_addr  = req_addr[31:2];
    dm_pc    = req_pc;
    if (w_drain) begin
      dm_we    = r_mem[r_head].we;
      dm_wdata = r_mem[r_head].data;
      dm_addr  = r_mem[r_head].waddr;
      dm_pc    = r_mem[r_head].pc;
    end
  end

  // Overlay pending store bytes on the DM word, oldest first so the newest wins.
  always_comb begin : load_merge
    logic [PW-1:0] v_idx;
    v_idx    = '0;
    w_merged = dm_rdata;
    for (int i = 0; i < DEPTH; i++) begin
      v_idx = r_head + PW'(i);
      if (r_valid[v_idx] && (r_mem[v_idx].waddr == req_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (r_mem[v_idx].we[b]) begin
            w_merged[8*b +: 8] = r_mem[v_idx].data[8*b +: 8];
          end
        end
      end
    end
  end

  // Align the addressed bytes to bit 0 and extend them to 32 bits.
  always_comb begin
    w_shift = w_merged >> {req_addr[1:0], 3'b000};
    case (req_size)
      2'd0:    w_ext = {{24{req_signed & w_shift[7]}}, w_shift[7:0]};
      2'd1:    w_ext = {{16{req_signed & w_shift[15]}}, w_shift[15:0]};
      default: w_ext = w_shift;
    endcase
  end

  assign load_data = w_load ? w_ext : '0;

  // Capture the formatted store at the tail slot.
  // NOTE: the payload array has no reset; r_valid and the pointers define
  // occupancy, so stale payload is never driven out or forwarded.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_tail] <= '{waddr: req_addr[31:2], we: w_st_we,
                         data: w_st_data, pc: req_pc};
    end
  end

  // Advance head/tail independently and track occupancy; reset drops all stores.
  // NOTE: non-blocking assignments make every register see pre-edge values,
  // so the push and pop in the same cycle cannot observe each other.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Sits between the MEM-stage load/store request and the data memory (DM).
- Formats stores into byte-enable / lane-replicated words and queues them in a FIFO of DEPTH entries.
- Drains one queued store to the DM per cycle when the DM port is free. Loads have priority on the DM's shared address port.
- Serves loads from DM read data, merged with pending buffered bytes (store-to-load forwarding), then extracts, sign-extends or zero-extends the result, and flags misaligned accesses.

Parameters:
DEPTH, 4, store queue entries; power of two, >= 2.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  memory request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
req_signed  in  1  load sign-extend enable
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
req_pc  in  32  PC of requesting instruction
req_ready  out  1  store can be accepted; loads are always ready
req_err  out  1  misaligned or illegal request this cycle (combinational)
load_data  out  32  extended load result (combinational)
drain_stall  in  1  inhibit draining (DMA/debug hold)
sb_empty  out  1  queue empty
dm_pc  out  32  PC forwarded with the write
dm_addr  out  30  word address, bits [31:2]
dm_wdata  out  32  lane-formatted write data
dm_we  out  4  per-byte write enable
dm_rdata  in  32  DM read word at dm_addr

Behaviour:
- Reset state:
  - count = 0, head/tail pointers = 0, all entries invalid.
  - sb_empty = 1, req_ready = 1, dm_we = 0.
  - Reset mid-operation discards all pending stores; nothing is written.
- Error detection:
  - err = valid request with any of: size 3; half with addr[0] = 1; word with addr[1:0] != 0.
  - An erroring request is consumed and dropped: no enqueue, load_data = 0, req_err = 1 that cycle.
- Store formatting, for byte lane b = addr[1:0]:
  - Byte: we = 1<<b; data = 4 copies of wdata[7:0].
  - Half: we = addr[1] ? 1100 : 0011; data = 2 copies of wdata[15:0].
  - Word: we = 1111; data = wdata.
- Enqueue:
  - req_valid & req_we & !err & req_ready writes {addr[31:2], we, data, pc} at tail on the clock edge.
  - req_ready = (count != DEPTH), decoded from registered count.
  - A store presented while ready = 0 is not accepted; the requester holds it.
- Drain:
  - Condition: count != 0 & !drain_stall & !(req_valid & !req_we).
  - When draining, drive dm_addr/dm_we/dm_wdata/dm_pc from the head entry and pop it at the edge.
  - Otherwise drive dm_we = 0 and dm_addr = req_addr[31:2].
  - dm_pc = head pc when draining, else req_pc.
- Simultaneous enqueue and drain: count unchanged; the pointers advance independently and wrap modulo DEPTH.
- Full with a drain this cycle: req_ready stays 0 this cycle and becomes 1 the next.
- Load path, same cycle as the request:
  - Start with w = dm_rdata.
  - For each valid entry, oldest to newest, whose word address equals req_addr[31:2], overwrite the bytes of w that are set in its we mask with the entry's data.
  - The newest entry wins.
  - Shift w right by 8*addr[1:0].
  - Byte: extend bit 7. Half: extend bit 15. Word: pass through. Extension is sign if req_signed, else zero.
- load_data = 0 when there is no valid load.
- sb_empty = (count == 0).
- DM write ordering equals program store order. No coalescing.

Test Plan:
- Reset -> sb_empty = 1, req_ready = 1, dm_we = 0; reset asserted with 3 entries queued -> count 0 and no dm_we in the following cycles.
- Byte store, addr 0x00000013, wdata 0xAB, buffer empty -> enqueued. Next cycle: dm_addr = 0x4, dm_we = 1000, dm_wdata = 0xABABABAB; then sb_empty = 1.
- Forwarding: sw 0x100 = 0x11223344, then next cycle lb 0x101 unsigned with dm_rdata = 0 -> load_data = 0x00000033, drain suppressed that cycle. With 0x80 in byte 3: lb signed 0x103 -> 0xFFFFFF80; lhu 0x102 -> 0x00001122 style extraction verified.
- Byte-order merge: drain_stall = 1, sb 0x200 = 0x11, then sb 0x200 = 0x22; lw 0x200 with dm_rdata 0xAABBCCDD -> 0xAABBCC22.
- Full and drain:
  - drain_stall = 1, four sw accepted -> req_ready = 0, fifth sw held.
  - Release stall -> four consecutive DM writes in order; req_ready = 1 after the first pop; the held fifth sw is accepted.
- Misaligned requests:
  - lh 0x101 -> req_err = 1, load_data = 0.
  - sw 0x102 -> req_err = 1, count unchanged, no DM write.
  - size 3 -> req_err = 1.
